name_assembler: RTL
===================

Name: name_assembler

Overview:
- Producer-side front end of the FIB lookup pipeline.
- Accepts a name as a stream of WORD_SIZE-bit components on a valid/ready handshake, delimited by a last flag.
- Assembles the components into the parallel, zero-filled MAX_NAME_LENGTH-word vector that the level pipeline consumes, and presents it with valid/ready.
- Double-buffered (assembly buffer plus output register), so back-to-back names stream without bubbles while the downstream side accepts.

Parameters:
- WORD_SIZE, 64, width of one name component word.
- MAX_NAME_LENGTH, 16, maximum name length in words; words beyond this are overflow.
- LEN_WIDTH, $clog2(MAX_NAME_LENGTH+1) = 5, width of the length field.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- word_in  input  WORD_SIZE  name component word.
- word_valid_in  input  1  word_in/word_last_in are valid.
- word_last_in  input  1  current word is the final component of the name.
- word_ready_out  output  1  block accepts a word this cycle.
- name_out  output  [WORD_SIZE-1:0] x MAX_NAME_LENGTH  assembled name; unused words are zero.
- name_len_out  output  LEN_WIDTH  number of valid words in name_out (1..MAX_NAME_LENGTH).
- name_trunc_out  output  1  name_out holds a truncated name.
- name_valid_out  output  1  name_out/name_len_out/name_trunc_out are valid.
- name_ready_in  input  1  downstream accepts the name this cycle.
- overflow_pulse_out  output  1  one-cycle pulse when an overlong name completes.

Behaviour:
- Reset (async, any time, including mid-name):
  - Clears the assembly buffer, word count, FSM (to FILL), output register and all outputs.
  - Outputs after reset: name_out=0, name_len_out=0, name_trunc_out=0, name_valid_out=0, overflow_pulse_out=0.
  - Any partial name is lost. word_ready_out=1 while rst=0 in FILL.
- Word accept: word_valid_in && word_ready_out. Output accept: name_valid_out && name_ready_in.
- "Slot free" means name_valid_out==0 or an output accept occurs this cycle.
- FSM states:
  - FILL: word_ready_out=1.
    - Accepted word with count<MAX_NAME_LENGTH is written to assembly index count; count increments.
    - Accepted word with count==MAX_NAME_LENGTH and last=0 -> DISCARD, trunc flag set, word ignored.
    - Accepted word with count==MAX_NAME_LENGTH and last=1 -> completes as a truncated name, word ignored.
  - DISCARD: word_ready_out=1. Accepted words are ignored. The accepted word with last=1 completes the name as truncated.
  - HOLD: word_ready_out=0. A complete name waits for the output slot. When the slot is free, transfer it and return to FILL; ready is high again the next cycle.
- Completion (the last word is accepted):
  - If the slot is free this cycle: the output register loads the assembly buffer (including the last word), len and trunc at the same edge. name_valid_out rises the next cycle (latency 1 from the last-word accept). The assembly buffer is zeroed, count=0, state FILL.
  - Otherwise: go to HOLD.
- Output register:
  - name_out, name_len_out and name_trunc_out are stable while name_valid_out=1 and name_ready_in=0.
  - name_valid_out drops after an output accept unless a new name loads at the same edge; it stays 1 for back-to-back names.
- Truncated name:
  - name_len_out=MAX_NAME_LENGTH, name_trunc_out=1, words 0..MAX_NAME_LENGTH-1 kept.
  - overflow_pulse_out=1 for exactly the cycle after the last word is accepted.
- A single-word name (last on the first word) is legal: len=1, words 1..15 zero. An empty name is impossible.
- A name of exactly MAX_NAME_LENGTH words is not truncated.
- word_valid_in low while ready is high: no state change; gaps inside a name are allowed.

Optional Feature:
- Macro: NAME_ASSEMBLER_OVERFLOW_DROP_EN.
- Defined: an overlong name is dropped entirely.
  - No output-register load and no HOLD; the slot is untouched.
  - overflow_pulse_out still pulses; name_trunc_out is constant 0.
  - Assembly resets to FILL the cycle after last.
- Undefined: truncate-and-deliver behaviour as above.

Test Plan:
- Reset, then 3 words 0xA,0xB,0xC (last on 0xC), name_ready_in=1 -> the cycle after 0xC: name_valid_out=1, name_out[0..2]=A,B,C, [3..15]=0, len=3, trunc=0; valid=0 the following cycle.
- name_ready_in=0; name1 (2 words) then name2 (1 word) -> name1 held stable; name2 parks in HOLD and word_ready_out=0. name_ready_in=1 for one cycle -> name2 appears next cycle; ready returns high one cycle later.
- Continuous names of 1 word each, name_ready_in=1 -> word_ready_out stays 1, name_valid_out high every cycle, len=1 each.
- 18-word name 1..18, macro off -> len=16, name_out[15]=16, trunc=1, overflow_pulse_out high one cycle; same stimulus with NAME_ASSEMBLER_OVERFLOW_DROP_EN -> no name_valid_out, pulse only.
- Exactly 16 words -> len=16, trunc=0, no pulse.
- Assert rst after 5 words of a name, then send 2-word name 0x1,0x2 -> output len=2, name_out[0..1]=1,2, no residue from the aborted name.

Source files
------------

// File: rtl/name_assembler_if.sv
// Name assembler bus: word stream in (producer side), assembled name out
// (consumer side).
interface name_assembler_if #(
  parameter int WORD_SIZE       = 64,
  parameter int MAX_NAME_LENGTH = 16,
  parameter int LEN_WIDTH       = $clog2(MAX_NAME_LENGTH + 1)
) ();
  logic [WORD_SIZE-1:0]                       word_in;
  logic                                       word_valid_in;
  logic                                       word_last_in;
  logic                                       word_ready_out;
  logic [MAX_NAME_LENGTH-1:0][WORD_SIZE-1:0]  name_out;
  logic [LEN_WIDTH-1:0]                       name_len_out;
  logic                                       name_trunc_out;
  logic                                       name_valid_out;
  logic                                       name_ready_in;
  logic                                       overflow_pulse_out;

  // Both channels: a transfer happens on a rising clk edge where valid and
  // ready are both high; a source holds valid and its payload stable until
  // that transfer, and valid never depends combinationally on ready.
  modport slave (
    input  word_in, word_valid_in, word_last_in, name_ready_in,
    output word_ready_out, name_out, name_len_out, name_trunc_out,
           name_valid_out, overflow_pulse_out
  );

  modport master (
    output word_in, word_valid_in, word_last_in, name_ready_in,
    input  word_ready_out, name_out, name_len_out, name_trunc_out,
           name_valid_out, overflow_pulse_out
  );
endinterface

// File: rtl/name_assembler.sv
// Assembles a streamed name into a zero-filled parallel word vector.
// Build option NAME_ASSEMBLER_OVERFLOW_DROP_EN drops overlong names instead of truncating.
module name_assembler #(
  parameter int WORD_SIZE       = 64,
  parameter int MAX_NAME_LENGTH = 16,
  parameter int LEN_WIDTH       = $clog2(MAX_NAME_LENGTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  name_assembler_if.slave       bus,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    DISCARD = 2'd1,
    HOLD    = 2'd2
  } state_e;

  typedef logic [MAX_NAME_LENGTH-1:0][WORD_SIZE-1:0] name_t;

  localparam int                   IDX_W   = (MAX_NAME_LENGTH > 1) ? $clog2(MAX_NAME_LENGTH) : 1;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_NAME_LENGTH);
  localparam logic [LEN_WIDTH-1:0] ONE_LEN = LEN_WIDTH'(1);

  state_e               state_q, state_d;
  name_t                asm_q, asm_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic                 trunc_q, trunc_d;
  name_t                out_name_q, out_name_d;
  logic [LEN_WIDTH-1:0] out_len_q, out_len_d;
  logic                 out_trunc_q, out_trunc_d;
  logic                 out_valid_q, out_valid_d;
  logic                 ovf_q, ovf_d;

  logic                 word_acc, out_acc, slot_free;
  logic                 done, done_trunc, load, clear_asm;
  logic [LEN_WIDTH-1:0] done_len, load_len;
  logic                 load_trunc;
  name_t                load_name;

  assign bus.word_ready_out = (state_q != HOLD);
  assign word_acc  = bus.word_valid_in && bus.word_ready_out;
  assign out_acc   = out_valid_q && bus.name_ready_in;
  assign slot_free = !out_valid_q || out_acc;

  always_comb begin
    state_d     = state_q;
    asm_d       = asm_q;
    count_d     = count_q;
    trunc_d     = trunc_q;
    out_name_d  = out_name_q;
    out_len_d   = out_len_q;
    out_trunc_d = out_trunc_q;
    out_valid_d = out_valid_q;
    ovf_d       = 1'b0;
    done        = 1'b0;
    done_len    = count_q;
    done_trunc  = 1'b0;
    load        = 1'b0;
    load_name   = asm_q;
    load_len    = count_q;
    load_trunc  = trunc_q;
    clear_asm   = 1'b0;

    case (state_q)
      FILL: begin
        if (word_acc) begin
          if (count_q < MAX_LEN) begin
            asm_d[count_q[IDX_W-1:0]] = bus.word_in;
            count_d = count_q + ONE_LEN;
            if (bus.word_last_in) begin
              done     = 1'b1;
              done_len = count_q + ONE_LEN;
            end
          end else if (bus.word_last_in) begin
            done       = 1'b1;
            done_len   = MAX_LEN;
            done_trunc = 1'b1;
          end else begin
            state_d = DISCARD;
            trunc_d = 1'b1;
          end
        end
      end
      DISCARD: begin
        if (word_acc && bus.word_last_in) begin
          done       = 1'b1;
          done_len   = MAX_LEN;
          done_trunc = 1'b1;
        end
      end
      HOLD: begin
        if (slot_free) begin
          load      = 1'b1;
          clear_asm = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase

    // Completion either hands the name straight to the output register or parks it in HOLD.
    if (done) begin
      ovf_d = done_trunc;
`ifdef NAME_ASSEMBLER_OVERFLOW_DROP_EN
      if (done_trunc) begin
        clear_asm = 1'b1;
      end else
`endif
      if (slot_free) begin
        load       = 1'b1;
        load_name  = asm_d;
        load_len   = done_len;
        load_trunc = done_trunc;
        clear_asm  = 1'b1;
      end else begin
        state_d = HOLD;
        count_d = done_len;
        trunc_d = done_trunc;
      end
    end

    if (clear_asm) begin
      asm_d   = '0;
      count_d = '0;
      trunc_d = 1'b0;
      state_d = FILL;
    end

    if (load) begin
      out_name_d  = load_name;
      out_len_d   = load_len;
      out_trunc_d = load_trunc;
      out_valid_d = 1'b1;
    end else if (out_acc) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      asm_q       <= '0;
      count_q     <= '0;
      trunc_q     <= 1'b0;
      out_name_q  <= '0;
      out_len_q   <= '0;
      out_trunc_q <= 1'b0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      asm_q       <= asm_d;
      count_q     <= count_d;
      trunc_q     <= trunc_d;
      out_name_q  <= out_name_d;
      out_len_q   <= out_len_d;
      out_trunc_q <= out_trunc_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.name_out           = out_name_q;
  assign bus.name_len_out       = out_len_q;
  assign bus.name_trunc_out     = out_trunc_q;
  assign bus.name_valid_out     = out_valid_q;
  assign bus.overflow_pulse_out = ovf_q;
  assign state_o                = state_q;

endmodule
